// File: rtl/uart_rx_fifo_if.sv
// Valid/ready handshake carrying received words from the UART receiver to its consumer.
interface uart_rx_fifo_if #(
   parameter int unsigned DATA_BITS = 8
);
   logic [DATA_BITS-1:0] data;
   logic                 valid;
   logic                 ready;

   modport master (output data, output valid, input ready);
   modport slave  (input data, input valid, output ready);
endinterface

// File: rtl/uart_rx_fifo.sv
// Oversampling UART receiver with start-glitch rejection, framing/overrun detection and a
// receive FIFO. Defining UART_RX_PARITY_EN adds a checked parity bit after the data bits.
module uart_rx_fifo #(
   parameter int unsigned DATA_BITS  = 8,
   parameter int unsigned OVERSAMPLE = 16,
   parameter int unsigned DIV_W      = 11,
   parameter int unsigned STOP_BITS  = 1,
   parameter int unsigned FIFO_DEPTH = 4
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic [DIV_W-1:0] div_i,
   input  logic             rx_i,
   input  logic             parity_odd_i,
   uart_rx_fifo_if.master   rx_if,
   output logic             frame_err_o,
   output logic             parity_err_o,
   output logic             overrun_o,
   output logic             busy_o
);
   localparam int unsigned SW = $clog2(OVERSAMPLE);
   localparam int unsigned BW = $clog2(DATA_BITS + 1);
   localparam int unsigned AW = $clog2(FIFO_DEPTH);

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      START  = 3'd1,
      DATA   = 3'd2,
`ifdef UART_RX_PARITY_EN
      PARITY = 3'd3,
`endif
      STOP   = 3'd4,
      BREAK  = 3'd5
   } state_e;

   state_e                state_q, state_nxt;
   logic                  rx_meta_q, rx_s_q;
   logic [DIV_W-1:0]      div_cnt_q;
   logic [SW-1:0]         samp_q;
   logic [BW-1:0]         bit_q;
   logic [DATA_BITS-1:0]  shift_q;
   logic                  tick_c, mid_c, end_c, last_data_c, last_stop_c, perr_pend_c;
   logic                  start_c, samp_clr_c, samp_inc_c, bit_clr_c, bit_inc_c;
   logic                  shift_c, par_lat_c, push_c, ferr_c, perr_c;
   logic [DATA_BITS-1:0]  mem_q [FIFO_DEPTH];
   logic [AW:0]           wr_q, rd_q;
   logic                  empty_c, full_c, pop_c, wr_en_c;

   // Two-flop synchroniser for the asynchronous serial line
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         rx_meta_q <= 1'b1;
         rx_s_q    <= 1'b1;
      end else begin
         rx_meta_q <= rx_i;
         rx_s_q    <= rx_meta_q;
      end
   end

   assign tick_c      = (div_cnt_q == div_i);
   assign mid_c       = (samp_q == SW'(OVERSAMPLE / 2 - 1));
   assign end_c       = (samp_q == SW'(OVERSAMPLE - 1));
   assign last_data_c = (bit_q == BW'(DATA_BITS - 1));
   assign last_stop_c = (bit_q == BW'(STOP_BITS - 1));

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) state_q <= IDLE;
      else         state_q <= state_nxt;
   end

   always_comb begin
      state_nxt = state_q;
      case (state_q)
         IDLE:  if (!rx_s_q) state_nxt = START;
         START: if (tick_c && mid_c) state_nxt = rx_s_q ? IDLE : DATA;
`ifdef UART_RX_PARITY_EN
         DATA:   if (tick_c && end_c && last_data_c) state_nxt = PARITY;
         PARITY: if (tick_c && end_c) state_nxt = STOP;
`else
         DATA:   if (tick_c && end_c && last_data_c) state_nxt = STOP;
`endif
         STOP: begin
            if (tick_c && end_c) begin
               if (!rx_s_q)          state_nxt = BREAK;
               else if (last_stop_c) state_nxt = IDLE;
            end
         end
         BREAK:   if (rx_s_q) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Per-state datapath strobes; the push/error decision is made at the last stop sample
   always_comb begin
      start_c    = 1'b0;
      samp_clr_c = 1'b0;
      samp_inc_c = 1'b0;
      bit_clr_c  = 1'b0;
      bit_inc_c  = 1'b0;
      shift_c    = 1'b0;
      par_lat_c  = 1'b0;
      push_c     = 1'b0;
      ferr_c     = 1'b0;
      perr_c     = 1'b0;
      case (state_q)
         IDLE: begin
            if (!rx_s_q) begin
               start_c    = 1'b1;
               samp_clr_c = 1'b1;
            end
         end
         START: begin
            if (tick_c) begin
               if (mid_c) begin
                  samp_clr_c = 1'b1;
                  bit_clr_c  = 1'b1;
               end else begin
                  samp_inc_c = 1'b1;
               end
            end
         end
         DATA: begin
            if (tick_c) begin
               if (end_c) begin
                  shift_c    = 1'b1;
                  samp_clr_c = 1'b1;
                  bit_clr_c  = last_data_c;
                  bit_inc_c  = !last_data_c;
               end else begin
                  samp_inc_c = 1'b1;
               end
            end
         end
`ifdef UART_RX_PARITY_EN
         PARITY: begin
            if (tick_c) begin
               if (end_c) begin
                  par_lat_c  = 1'b1;
                  samp_clr_c = 1'b1;
                  bit_clr_c  = 1'b1;
               end else begin
                  samp_inc_c = 1'b1;
               end
            end
         end
`endif
         STOP: begin
            if (tick_c) begin
               if (end_c) begin
                  samp_clr_c = 1'b1;
                  if (!rx_s_q)          ferr_c    = 1'b1;
                  else if (!last_stop_c) bit_inc_c = 1'b1;
                  else if (perr_pend_c)  perr_c    = 1'b1;
                  else                   push_c    = 1'b1;
               end else begin
                  samp_inc_c = 1'b1;
               end
            end
         end
         default: ;
      endcase
   end

   // Tick divider restarts on the start edge so sampling lands mid-bit
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         div_cnt_q <= '0;
         samp_q    <= '0;
         bit_q     <= '0;
         shift_q   <= '0;
      end else begin
         if (start_c || tick_c) div_cnt_q <= '0;
         else                   div_cnt_q <= div_cnt_q + DIV_W'(1);
         if (samp_clr_c)        samp_q <= '0;
         else if (samp_inc_c)   samp_q <= samp_q + SW'(1);
         if (bit_clr_c)         bit_q <= '0;
         else if (bit_inc_c)    bit_q <= bit_q + BW'(1);
         if (shift_c)           shift_q <= {rx_s_q, shift_q[DATA_BITS-1:1]};
      end
   end

`ifdef UART_RX_PARITY_EN
   logic par_err_q;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni)        par_err_q <= 1'b0;
      else if (start_c)   par_err_q <= 1'b0;
      else if (par_lat_c) par_err_q <= ((^shift_q) ^ rx_s_q) != parity_odd_i;
   end

   assign perr_pend_c = par_err_q;
`else
   logic unused_parity;

   assign perr_pend_c   = 1'b0;
   assign unused_parity = parity_odd_i ^ par_lat_c;
`endif

   // FIFO with an extra wrap bit on each pointer to tell full from empty
   assign empty_c     = (wr_q == rd_q);
   assign full_c      = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
   assign pop_c       = rx_if.ready && !empty_c;
   assign wr_en_c     = push_c && (!full_c || pop_c);
   assign rx_if.valid = !empty_c;
   assign rx_if.data  = mem_q[rd_q[AW-1:0]];

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         for (int i = 0; i < int'(FIFO_DEPTH); i++) mem_q[i] <= '0;
         wr_q <= '0;
         rd_q <= '0;
      end else begin
         if (wr_en_c) begin
            mem_q[wr_q[AW-1:0]] <= shift_q;
            wr_q                <= wr_q + (AW+1)'(1);
         end
         if (pop_c) rd_q <= rd_q + (AW+1)'(1);
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         frame_err_o  <= 1'b0;
         parity_err_o <= 1'b0;
         overrun_o    <= 1'b0;
         busy_o       <= 1'b0;
      end else begin
         frame_err_o  <= ferr_c;
         parity_err_o <= perr_c;
         overrun_o    <= push_c && full_c && !pop_c;
         busy_o       <= (state_nxt != IDLE);
      end
   end
endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed and randomized frames checked against a queue-based model of received words and pulses.
module tb_uart_rx_fifo;
   localparam int unsigned BIT_CLKS = 16;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [10:0] div;
   logic        rx;
   logic        parity_odd;
   logic        frame_err, parity_err, overrun, busy;

   uart_rx_fifo_if #(.DATA_BITS(8)) rx_if ();

   uart_rx_fifo dut (
      .clk_i        (clk),
      .rst_ni       (rst_n),
      .div_i        (div),
      .rx_i         (rx),
      .parity_odd_i (parity_odd),
      .rx_if        (rx_if),
      .frame_err_o  (frame_err),
      .parity_err_o (parity_err),
      .overrun_o    (overrun),
      .busy_o       (busy)
   );

   always #5 clk = ~clk;

   int         n_checks = 0;
   int         n_fail   = 0;
   logic [7:0] got_q [$];
   int         n_ferr = 0, n_perr = 0, n_ovr = 0, n_valid = 0;

   // Observe the consumer side and the pulses away from the active edge
   always @(negedge clk) begin
      if (rst_n) begin
         if (rx_if.valid && rx_if.ready) got_q.push_back(rx_if.data);
         if (rx_if.valid) n_valid++;
         if (frame_err)   n_ferr++;
         if (parity_err)  n_perr++;
         if (overrun)     n_ovr++;
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic cyc(input int n);
      repeat (n) @(posedge clk);
      #2;
   endtask

   task automatic send_frame(input logic [7:0] d, input bit stop_ok, input bit par_ok);
      rx = 1'b0;
      cyc(BIT_CLKS);
      for (int i = 0; i < 8; i++) begin
         rx = d[i];
         cyc(BIT_CLKS);
      end
`ifdef UART_RX_PARITY_EN
      rx = (parity_odd ^ (^d)) ^ !par_ok;
      cyc(BIT_CLKS);
`endif
      rx = stop_ok;
      cyc(BIT_CLKS);
      rx = 1'b1;
   endtask

   initial begin
      int         g0, f0, p0, o0, v0;
      logic [7:0] exp_q [$];
      logic [7:0] d;
      bit         ok;
      int         exp_ferr;

      rst_n = 1'b0; div = '0; rx = 1'b1; parity_odd = 1'b1; rx_if.ready = 1'b1;
      cyc(3);
      check("reset_valid", 32'(rx_if.valid), 0);
      check("reset_data",  32'(rx_if.data), 0);
      check("reset_busy",  32'(busy), 0);
      check("reset_pulses", {29'd0, frame_err, parity_err, overrun}, 0);
      rst_n = 1'b1;
      cyc(4);

      // 0xA5 8N1
      g0 = got_q.size(); f0 = n_ferr; p0 = n_perr; o0 = n_ovr; v0 = n_valid;
      send_frame(8'hA5, 1'b1, 1'b1);
      cyc(20);
      check("a5_count", 32'(got_q.size() - g0), 1);
      if (got_q.size() > g0) check("a5_data", 32'(got_q[g0]), 32'hA5);
      check("a5_valid_cycles", 32'(n_valid - v0), 1);
      check("a5_pulses", 32'((n_ferr - f0) + (n_perr - p0) + (n_ovr - o0)), 0);
      check("a5_busy", 32'(busy), 0);

`ifdef UART_RX_PARITY_EN
      g0 = got_q.size(); p0 = n_perr;
      send_frame(8'h01, 1'b1, 1'b1);
      cyc(20);
      send_frame(8'h01, 1'b1, 1'b0);
      cyc(20);
      check("par_count", 32'(got_q.size() - g0), 1);
      if (got_q.size() > g0) check("par_data", 32'(got_q[g0]), 32'h01);
      check("par_err", 32'(n_perr - p0), 1);
`endif

      // Start glitch shorter than half a bit
      g0 = got_q.size(); f0 = n_ferr; p0 = n_perr;
      rx = 1'b0;
      cyc(5);
      check("glitch_busy_hi", 32'(busy), 1);
      rx = 1'b1;
      cyc(30);
      check("glitch_busy_lo", 32'(busy), 0);
      check("glitch_nopush", 32'(got_q.size() - g0), 0);
      check("glitch_nopulse", 32'((n_ferr - f0) + (n_perr - p0)), 0);

      // Bad stop bit followed by a held-low line
      g0 = got_q.size(); f0 = n_ferr;
      send_frame(8'h3C, 1'b0, 1'b1);
      rx = 1'b0;
      cyc(200);
      check("break_ferr", 32'(n_ferr - f0), 1);
      check("break_valid", 32'(rx_if.valid), 0);
      check("break_busy", 32'(busy), 1);
      rx = 1'b1;
      cyc(6);
      check("break_release", 32'(busy), 0);
      check("break_nopush", 32'(got_q.size() - g0), 0);

      // Fill the FIFO, then one more frame overruns
      rx_if.ready = 1'b0;
      o0 = n_ovr; g0 = got_q.size();
      for (int i = 1; i <= 4; i++) begin
         send_frame(8'(i), 1'b1, 1'b1);
         cyc(4);
      end
      check("fill_no_ovr", 32'(n_ovr - o0), 0);
      send_frame(8'h05, 1'b1, 1'b1);
      cyc(20);
      check("ovr_once", 32'(n_ovr - o0), 1);
      check("ovr_valid", 32'(rx_if.valid), 1);
      rx_if.ready = 1'b1;
      cyc(10);
      check("ovr_pop_count", 32'(got_q.size() - g0), 4);
      for (int i = 0; i < 4; i++)
         if (got_q.size() > g0 + i) check("ovr_pop_order", 32'(got_q[g0 + i]), 32'(i + 1));
      check("ovr_empty", 32'(rx_if.valid), 0);

      // Reset in the middle of a frame
      f0 = n_ferr; p0 = n_perr; o0 = n_ovr;
      rx = 1'b0;
      cyc(BIT_CLKS);
      rx = 1'b1;
      cyc(4 * BIT_CLKS);
      rst_n = 1'b0;
      cyc(3);
      rst_n = 1'b1;
      cyc(2);
      check("rst_busy", 32'(busy), 0);
      g0 = got_q.size();
      cyc(6 * BIT_CLKS);
      check("rst_nopartial", 32'(got_q.size() - g0), 0);
      send_frame(8'h42, 1'b1, 1'b1);
      cyc(20);
      check("rst_count", 32'(got_q.size() - g0), 1);
      if (got_q.size() > g0) check("rst_data", 32'(got_q[g0]), 32'h42);
      check("rst_nopulse", 32'((n_ferr - f0) + (n_perr - p0) + (n_ovr - o0)), 0);

      // Random frames, some with bad stop bits, some back-to-back
      g0 = got_q.size(); f0 = n_ferr; o0 = n_ovr; p0 = n_perr;
      exp_ferr = 0;
      for (int i = 0; i < 24; i++) begin
         d  = 8'($urandom);
         ok = ($urandom_range(0, 4) != 0);
         send_frame(d, ok, 1'b1);
         if (ok) begin
            exp_q.push_back(d);
            cyc($urandom_range(0, 12));
         end else begin
            exp_ferr++;
            cyc($urandom_range(4, 12));
         end
      end
      cyc(40);
      check("rnd_count", 32'(got_q.size() - g0), 32'(exp_q.size()));
      for (int i = 0; i < exp_q.size(); i++)
         if (got_q.size() > g0 + i) check("rnd_data", 32'(got_q[g0 + i]), 32'(exp_q[i]));
      check("rnd_ferr", 32'(n_ferr - f0), 32'(exp_ferr));
      check("rnd_ovr", 32'(n_ovr - o0), 0);
      check("rnd_perr", 32'(n_perr - p0), 0);
      check("rnd_idle", 32'(busy), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
